// File: rtl/vend_dispenser.sv
// -----------------------------------------------------------------------------
// vend_dispenser
//
// Actuator stage behind vending_machine_top. A one-cycle vend request
// (soda_i) starts a transaction. The soda-release motor is pulsed first. The
// change owed (change_i, counted in nickels) is then paid out dime-first, with
// one solenoid pulse per coin. Every ejected coin must be confirmed by the
// coin-drop sensor. A confirmation that never arrives latches a jam fault,
// which only an operator clear releases.
//
// Ports:
//   clk_i          in   clock, rising edge
//   reset_i        in   synchronous active-high reset
//   soda_i         in   one-cycle vend request
//   change_i[2:0]  in   change owed in nickels, sampled only with soda_i in IDLE
//   coin_seen_i    in   coin-drop sensor pulse, one per ejected coin
//   clear_fault_i  in   operator fault clear
//   soda_motor_o   out  soda-release motor drive
//   dime_eject_o   out  dime solenoid drive
//   nickel_eject_o out  nickel solenoid drive
//   busy_o         out  high whenever the controller is not idle
//   fault_o        out  jam fault, high only while faulted
//   dropped_o      out  one-cycle pulse when a vend request is rejected
// -----------------------------------------------------------------------------
module vend_dispenser #(
    parameter int PULSE_CYCLES   = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       soda_i,
    input  logic [2:0] change_i,
    input  logic       coin_seen_i,
    input  logic       clear_fault_i,
    output logic       soda_motor_o,
    output logic       dime_eject_o,
    output logic       nickel_eject_o,
    output logic       busy_o,
    output logic       fault_o,
    output logic       dropped_o
);

    localparam int PW = (PULSE_CYCLES   > 1) ? $clog2(PULSE_CYCLES)   : 1;
    localparam int GW = (GAP_CYCLES     > 1) ? $clog2(GAP_CYCLES)     : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SODA,
        S_GAP,
        S_COIN,
        S_WAIT_ACK,
        S_FAULT
    } state_t;

    state_t        state;
    logic [2:0]    remaining;
    logic          dime_sel;
    logic          ack_seen;
    logic [PW-1:0] pulse_cnt;
    logic [GW-1:0] gap_cnt;
    logic [TW-1:0] to_cnt;

    // Value in nickels of the coin currently being ejected.
    function automatic logic [2:0] coin_value(input logic dime);
        return dime ? 3'd2 : 3'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state          <= S_IDLE;
            remaining      <= 3'd0;
            dime_sel       <= 1'b0;
            ack_seen       <= 1'b0;
            pulse_cnt      <= '0;
            gap_cnt        <= '0;
            to_cnt         <= '0;
            soda_motor_o   <= 1'b0;
            dime_eject_o   <= 1'b0;
            nickel_eject_o <= 1'b0;
            busy_o         <= 1'b0;
            fault_o        <= 1'b0;
            dropped_o      <= 1'b0;
        end else begin
            // Requests are never queued: anything outside IDLE is dropped,
            // including the cycle in which GAP or FAULT hands back to IDLE.
            dropped_o <= soda_i && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (soda_i) begin
                        remaining    <= change_i;
                        pulse_cnt    <= '0;
                        soda_motor_o <= 1'b1;
                        busy_o       <= 1'b1;
                        state        <= S_SODA;
                    end
                end

                S_SODA: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        soda_motor_o <= 1'b0;
                        gap_cnt      <= '0;
                        state        <= S_GAP;
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        pulse_cnt <= '0;
                        ack_seen  <= 1'b0;
                        // Dime-first: a dime is only chosen with at least two
                        // nickels owed, so remaining can never underflow.
                        if (remaining >= 3'd2) begin
                            dime_sel     <= 1'b1;
                            dime_eject_o <= 1'b1;
                            state        <= S_COIN;
                        end else if (remaining == 3'd1) begin
                            dime_sel       <= 1'b0;
                            nickel_eject_o <= 1'b1;
                            state          <= S_COIN;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                S_COIN: begin
                    if (coin_seen_i) begin
                        ack_seen <= 1'b1;
                    end
                    if (pulse_cnt == PULSE_LAST) begin
                        dime_eject_o   <= 1'b0;
                        nickel_eject_o <= 1'b0;
                        // An ack on the final pulse cycle counts as in-pulse.
                        if (ack_seen || coin_seen_i) begin
                            remaining <= remaining - coin_value(dime_sel);
                            ack_seen  <= 1'b0;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end else begin
                            to_cnt <= '0;
                            state  <= S_WAIT_ACK;
                        end
                    end else begin
                        pulse_cnt <= pulse_cnt + PW'(1);
                    end
                end

                S_WAIT_ACK: begin
                    // A late ack on the last allowed cycle still wins over
                    // the timeout.
                    if (coin_seen_i) begin
                        remaining <= remaining - coin_value(dime_sel);
                        gap_cnt   <= '0;
                        state     <= S_GAP;
                    end else if (to_cnt == TIMEOUT_LAST) begin
                        remaining <= 3'd0;
                        fault_o   <= 1'b1;
                        state     <= S_FAULT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end

                S_FAULT: begin
                    if (clear_fault_i) begin
                        fault_o <= 1'b0;
                        busy_o  <= 1'b0;
                        state   <= S_IDLE;
                    end
                end

                default: begin
                    soda_motor_o   <= 1'b0;
                    dime_eject_o   <= 1'b0;
                    nickel_eject_o <= 1'b0;
                    busy_o         <= 1'b0;
                    fault_o        <= 1'b0;
                    state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
Downstream actuator stage for vending_machine_top. It consumes the one-cycle soda_o pulse and the 3-bit change_o value, which counts change in nickels. It drives the soda-release motor and the dime/nickel coin-eject solenoids with timed pulses. Each ejected coin must be confirmed by the coin-drop sensor; a missing confirmation raises a latched jam fault.

Parameters:
PULSE_CYCLES, 4, on-time in clock cycles of every motor or solenoid pulse (>=1)
GAP_CYCLES, 2, all-outputs-low cycles after each pulse or confirmation (>=1)
TIMEOUT_CYCLES, 16, maximum cycles in WAIT_ACK before fault (>=1)

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  synchronous, active-high reset
soda_i  input  1  one-cycle vend request from vending_machine_top soda_o
change_i  input  3  change owed in nickels, sampled only when soda_i=1
coin_seen_i  input  1  coin-drop sensor pulse, one per ejected coin
clear_fault_i  input  1  operator fault clear
soda_motor_o  output  1  soda-release motor drive
dime_eject_o  output  1  dime solenoid drive
nickel_eject_o  output  1  nickel solenoid drive
busy_o  output  1  high in every state except IDLE
fault_o  output  1  jam fault, high only in FAULT
dropped_o  output  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset (reset_i=1 at a clock edge, any state): state=IDLE, remaining=0, all counters=0, all outputs=0. Reset overrides every other input on the same edge.
- Only one output among soda_motor_o, dime_eject_o, nickel_eject_o is high at any time. All are registered.
- States: IDLE, SODA, GAP, COIN, WAIT_ACK, FAULT.
- IDLE: soda_i=1 at edge t -> remaining<=change_i, enter SODA. soda_motor_o is high for cycles t+1..t+PULSE_CYCLES. soda_i=0 -> change_i is ignored.
- SODA: after PULSE_CYCLES cycles -> GAP.
- GAP: all drives low for GAP_CYCLES cycles, then:
  - remaining>=2 -> COIN with dime selected
  - remaining==1 -> COIN with nickel selected
  - remaining==0 -> IDLE
- COIN: the selected eject output is high for PULSE_CYCLES cycles.
  - If coin_seen_i=1 on any COIN cycle, the ack is latched. At pulse end: remaining -= 2 (dime) or 1 (nickel), then GAP.
  - If no ack during the pulse -> WAIT_ACK.
- WAIT_ACK: drives low.
  - coin_seen_i=1 -> decrement as above, then GAP.
  - TIMEOUT_CYCLES cycles elapse with no ack -> FAULT.
- FAULT: all drives low, fault_o=1, remaining is discarded (zeroed).
  - clear_fault_i=1 -> IDLE on the next edge.
  - soda_i is rejected while in FAULT.
- Rejected requests: soda_i=1 in any state other than IDLE (including the exit cycle of GAP/FAULT) -> dropped_o=1 for the next cycle; the request is not queued.
- coin_seen_i in IDLE, SODA, GAP or FAULT is ignored and does not count as an ack. Only one ack is credited per coin; extra sensor pulses within the same COIN/WAIT_ACK are ignored.
- change_i is treated as an unsigned value 0..7 with the same dime-first algorithm. Coin sequence is floor(n/2) dimes followed by n mod 2 nickels, e.g. 7 -> D,D,D,N.
- Arithmetic: remaining is 3-bit and never underflows, because a dime is selected only when remaining>=2.
- Timeout counter width is sized to TIMEOUT_CYCLES; pulse and gap counters are sized to their parameters.
- Transaction length with prompt acks (coin_seen_i inside the pulse) and n nickels of change: (PULSE_CYCLES+GAP_CYCLES)*(1+floor(n/2)+(n mod 2)) cycles. busy_o is high for exactly that span.

Test Plan:
- soda_i=1, change_i=0 at edge 0 -> soda_motor_o high cycles 1-4; busy_o high cycles 1-6; IDLE at cycle 7; no eject pulses.
- soda_i=1, change_i=3, coin_seen_i pulsed in cycle 2 of each eject -> soda 1-4, dime_eject_o 7-10, nickel_eject_o 13-16; busy_o falls at cycle 19.
- change_i=4, coin_seen_i withheld after the first dime -> second dime pulse, then 16 WAIT_ACK cycles, then fault_o=1 with all drives 0. clear_fault_i -> IDLE; busy_o=0; remaining=0.
- change_i=1, ack arrives in WAIT_ACK cycle 16 -> no fault; nickel credited; return to IDLE after GAP.
- soda_i re-asserted during SODA and again during FAULT -> dropped_o pulses one cycle each; outputs and remaining unchanged.
- reset_i asserted mid dime pulse -> next edge: dime_eject_o=0, busy_o=0, state IDLE. A subsequent soda_i with change_i=2 runs normally (soda then one dime).
